// File: rtl/vx_dispatch_gather_if.sv
// Bundle of signals between a SIMD dispatch source, the gather stage and the
// full-warp consumer.
//   in_*   : one dispatch beat carrying SIMD_WIDTH lanes of slice in_sid,
//            plus the instruction header and the sop/eop framing flags.
//   in_ready  : the gather stage accepts the beat when in_valid && in_ready.
//   out_*  : an assembled NUM_LANES-wide instruction, held while out_valid.
//   out_ready : the consumer takes the instruction when out_valid && out_ready.
// Modports:
//   master : the testbench/upstream side, which drives beats and out_ready.
//   slave  : the gather stage.
interface vx_dispatch_gather_if #(
  parameter int NUM_LANES  = 16,
  parameter int SIMD_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int UUID_WIDTH = 44,
  parameter int WIS_W      = 2,
  parameter int PC_BITS    = 30,
  parameter int OP_BITS    = 4,
  parameter int NR_BITS    = 6
);
  localparam int SIMD_COUNT = NUM_LANES / SIMD_WIDTH;
  localparam int SIMD_IDX_W = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;

  logic                         in_valid;
  logic [UUID_WIDTH-1:0]        in_uuid;
  logic [WIS_W-1:0]             in_wis;
  logic [PC_BITS-1:0]           in_PC;
  logic [OP_BITS-1:0]           in_op_type;
  logic                         in_wb;
  logic [NR_BITS-1:0]           in_rd;
  logic [SIMD_IDX_W-1:0]        in_sid;
  logic [SIMD_WIDTH-1:0]        in_tmask;
  logic [SIMD_WIDTH*XLEN-1:0]   in_rs1_data;
  logic [SIMD_WIDTH*XLEN-1:0]   in_rs2_data;
  logic                         in_sop;
  logic                         in_eop;
  logic                         in_ready;

  logic                         out_valid;
  logic [UUID_WIDTH-1:0]        out_uuid;
  logic [WIS_W-1:0]             out_wis;
  logic [PC_BITS-1:0]           out_PC;
  logic [OP_BITS-1:0]           out_op_type;
  logic                         out_wb;
  logic [NR_BITS-1:0]           out_rd;
  logic [NUM_LANES-1:0]         out_tmask;
  logic [NUM_LANES*XLEN-1:0]    out_rs1_data;
  logic [NUM_LANES*XLEN-1:0]    out_rs2_data;
  logic                         out_ready;

  modport master (
    output in_valid, in_uuid, in_wis, in_PC, in_op_type, in_wb, in_rd,
           in_sid, in_tmask, in_rs1_data, in_rs2_data, in_sop, in_eop,
    input  in_ready,
    input  out_valid, out_uuid, out_wis, out_PC, out_op_type, out_wb, out_rd,
           out_tmask, out_rs1_data, out_rs2_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_uuid, in_wis, in_PC, in_op_type, in_wb, in_rd,
           in_sid, in_tmask, in_rs1_data, in_rs2_data, in_sop, in_eop,
    output in_ready,
    output out_valid, out_uuid, out_wis, out_PC, out_op_type, out_wb, out_rd,
           out_tmask, out_rs1_data, out_rs2_data,
    input  out_ready
  );
endinterface

// File: rtl/vx_dispatch_gather.sv
// Gathers SIMD_WIDTH-lane dispatch beats into one NUM_LANES-wide instruction.
// Each accepted beat writes its lane slice (in_sid) into the output registers;
// the sop beat also captures the header and clears the mask of every other
// slice, so slices skipped between sop and eop read back with a zero mask.
// The eop beat completes the instruction, which is then held in FULL until the
// consumer takes it; a new beat can be accepted on the same edge it drains.
// Ports:
//   clk   : clock, all state on the rising edge.
//   reset : asynchronous active-high reset.
//   bus   : beat input / instruction output bundle (slave side).
//   err   : sticky protocol-violation flag, cleared only by reset.
module vx_dispatch_gather #(
  parameter int NUM_LANES  = 16,
  parameter int SIMD_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int UUID_WIDTH = 44,
  parameter int WIS_W      = 2,
  parameter int PC_BITS    = 30,
  parameter int OP_BITS    = 4,
  parameter int NR_BITS    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_dispatch_gather_if.slave  bus,
  output logic                 err
);
  localparam int SIMD_COUNT = NUM_LANES / SIMD_WIDTH;
  localparam int SIMD_IDX_W = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int SLICE_BITS = SIMD_WIDTH * XLEN;
  // One extra bit so the bound compare also works when SIMD_COUNT is a power of 2.
  localparam logic [SIMD_IDX_W:0] SIMD_COUNT_EXT = (SIMD_IDX_W + 1)'(SIMD_COUNT);

  typedef enum logic {COLLECT, FULL} state_e;

  state_e                 state_reg, state_next;
  logic                   open_reg;
  logic [SIMD_IDX_W-1:0]  last_sid_reg;
  logic                   err_reg;
  logic                   beat_fire;
  logic                   sid_ok;
  logic                   beat_err;

  logic [UUID_WIDTH-1:0]  uuid_reg;
  logic [WIS_W-1:0]       wis_reg;
  logic [PC_BITS-1:0]     pc_reg;
  logic [OP_BITS-1:0]     op_type_reg;
  logic                   wb_reg;
  logic [NR_BITS-1:0]     rd_reg;

  // In FULL a beat may only enter while the held instruction leaves.
  assign bus.in_ready = (state_reg == COLLECT) || bus.out_ready;
  assign beat_fire    = bus.in_valid && bus.in_ready;
  assign sid_ok       = {1'b0, bus.in_sid} < SIMD_COUNT_EXT;
  assign beat_err     = (!bus.in_sop && !open_reg)
                      || (bus.in_sop && open_reg)
                      || (!bus.in_sop && (bus.in_sid <= last_sid_reg))
                      || !sid_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.out_valid = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (beat_fire && bus.in_eop) begin
          state_next = FULL;
        end
      end
      FULL: begin
        bus.out_valid = 1'b1;
        // Drain; stay FULL only if a complete replacement arrives this edge.
        if (bus.out_ready && !(beat_fire && bus.in_eop)) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_reg     <= 1'b0;
      last_sid_reg <= '0;
      err_reg      <= 1'b0;
    end else if (beat_fire) begin
      last_sid_reg <= bus.in_sid;
      if (bus.in_eop) begin
        open_reg <= 1'b0;
      end else if (bus.in_sop) begin
        open_reg <= 1'b1;
      end
      if (beat_err) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire && bus.in_sop) begin
      uuid_reg    <= bus.in_uuid;
      wis_reg     <= bus.in_wis;
      pc_reg      <= bus.in_PC;
      op_type_reg <= bus.in_op_type;
      wb_reg      <= bus.in_wb;
      rd_reg      <= bus.in_rd;
    end
  end

  generate
    for (genvar gi = 0; gi < SIMD_COUNT; gi++) begin : g_slice
      logic                  slice_sel;
      logic [SIMD_WIDTH-1:0] tmask_reg;
      logic [SLICE_BITS-1:0] rs1_reg;
      logic [SLICE_BITS-1:0] rs2_reg;

      // An out-of-range sid matches no slice, so such a beat writes nothing.
      assign slice_sel = beat_fire && sid_ok && (bus.in_sid == SIMD_IDX_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tmask_reg <= '0;
        end else if (slice_sel) begin
          tmask_reg <= bus.in_tmask;
        end else if (beat_fire && bus.in_sop) begin
          tmask_reg <= '0;
        end
      end

      always_ff @(posedge clk) begin
        if (slice_sel) begin
          rs1_reg <= bus.in_rs1_data;
          rs2_reg <= bus.in_rs2_data;
        end
      end

      assign bus.out_tmask[gi*SIMD_WIDTH +: SIMD_WIDTH]    = tmask_reg;
      assign bus.out_rs1_data[gi*SLICE_BITS +: SLICE_BITS] = rs1_reg;
      assign bus.out_rs2_data[gi*SLICE_BITS +: SLICE_BITS] = rs2_reg;
    end
  endgenerate

  assign bus.out_uuid    = uuid_reg;
  assign bus.out_wis     = wis_reg;
  assign bus.out_PC      = pc_reg;
  assign bus.out_op_type = op_type_reg;
  assign bus.out_wb      = wb_reg;
  assign bus.out_rd      = rd_reg;
  assign err             = err_reg;
endmodule
